rx_frame_capture: RTL

- Upstream feeder of the ping-pong BRAM writer (bram_conect).
- Takes demodulated I/Q samples from the receiver chain at the ADC sample strobe.
- Applies a range-gate window: a blanking delay, then a capture length, both measured from each transmit sync pulse.
- Packs I/Q into 32-bit words and drives valid/sinc/datos_i of the BRAM writer.

---
 rtl/rx_pkg.sv | 8 +
 rtl/sync_rise_det.sv | 13 +
 rtl/rx_frame_capture.sv | 92 +++++++++
 3 files changed

// File: rtl/rx_pkg.sv
// rx_pkg: shared state encoding, widths and word packing layout for rx_frame_capture.
package rx_pkg;
   localparam int SAMPLE_W = 16;
   localparam int CNT_W    = 16;
   localparam int I_MSB    = 31;
   localparam int Q_MSB    = 15;
   typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, CAPTURE = 2'd2} state_t;
endpackage

// File: rtl/sync_rise_det.sv
// sync_rise_det: registers the transmit sync level and flags its rising edge.
module sync_rise_det (
   input  logic clk,
   input  logic rst_n,
   input  logic pulse_sync,
   output logic rise
);
   logic r_sync_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_sync_q <= 1'b0;
      else        r_sync_q <= pulse_sync;
   assign rise = pulse_sync & ~r_sync_q;
endmodule

// File: rtl/rx_frame_capture.sv
// rx_frame_capture: range-gated I/Q capture feeding the ping-pong BRAM writer.
// Define RX_FRAME_TEST_PATTERN_EN to emit {frame_cnt, sample_index} instead of ADC data.
module rx_frame_capture #(
   parameter int SAMPLE_W = rx_pkg::SAMPLE_W,
   parameter int CNT_W    = rx_pkg::CNT_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                adc_valid,
   input  logic [SAMPLE_W-1:0] adc_i,
   input  logic [SAMPLE_W-1:0] adc_q,
   input  logic                pulse_sync,
   input  logic                cfg_en,
   input  logic [CNT_W-1:0]    cfg_delay,
   input  logic [CNT_W-1:0]    cfg_len,
   output logic                valid,
   output logic                sinc,
   output logic [31:0]         datos_o,
   output logic                busy,
   output logic                overrun,
   output logic [CNT_W-1:0]    miss_cnt,
   output logic [CNT_W-1:0]    frame_cnt
);
   import rx_pkg::*;
   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_dly, r_len, r_cnt, r_miss, r_frame, w_cnt_inc;
   logic [31:0]        r_data, w_word;
   logic               r_valid, r_sinc, r_overrun;
   logic               w_rise, w_start, w_cap;
   sync_rise_det u_rise (
      .clk        (clk),
      .rst_n      (rst_n),
      .pulse_sync (pulse_sync),
      .rise       (w_rise)
   );
   assign w_cnt_inc = r_cnt + 1'b1;
   assign busy      = r_state != IDLE;
   assign w_start   = (r_state == IDLE) & w_rise & cfg_en;
   assign w_cap     = (r_state == CAPTURE) & adc_valid;
`ifdef RX_FRAME_TEST_PATTERN_EN
   assign w_word = {16'(r_frame), 16'(r_cnt)};
`else
   assign w_word[I_MSB -: SAMPLE_W] = adc_i;
   assign w_word[Q_MSB -: SAMPLE_W] = adc_q;
`endif
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_start && cfg_len != '0) w_state_nxt = (cfg_delay != '0) ? DELAY : CAPTURE;
         DELAY:   if (adc_valid && w_cnt_inc == r_dly) w_state_nxt = CAPTURE;
         CAPTURE: if (adc_valid && w_cnt_inc == r_len) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dly     <= '0;
         r_len     <= '0;
         r_cnt     <= '0;
         r_miss    <= '0;
         r_frame   <= '0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_sinc    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_valid <= w_cap;
         r_sinc  <= w_cap & (r_cnt == '0);
         if (w_cap) r_data <= w_word;
         // the counter restarts on every state change so it doubles as the sample index
         if (w_start) begin
            r_dly <= cfg_delay;
            r_len <= cfg_len;
            r_cnt <= '0;
         end else if (adc_valid && busy) r_cnt <= (w_state_nxt != r_state) ? '0 : w_cnt_inc;
         if (w_cap && w_state_nxt == IDLE) r_frame <= r_frame + 1'b1;
         if (busy && w_rise) begin
            r_overrun <= 1'b1;
            if (~&r_miss) r_miss <= r_miss + 1'b1;
         end
      end
   end
   assign valid     = r_valid;
   assign sinc      = r_sinc;
   assign datos_o   = r_data;
   assign overrun   = r_overrun;
   assign miss_cnt  = r_miss;
   assign frame_cnt = r_frame;
endmodule
